// File: rtl/midi_square_poly.sv
// midi_square_poly: MIDI byte stream to VOICES polyphonic square-wave oscillators.
// Ports: clk, rst (async high); rx_valid/rx_byte in; voice_out, voice_active, buzz, drop out.
// Optional macro M2S_VELOCITY_DUTY_EN: duty cycle follows note velocity.
module midi_square_poly #(
    parameter int VOICES  = 4,
    parameter int CHANNEL = 0,
    parameter int OMNI    = 0,
    parameter int CNT_W   = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic [VOICES-1:0] voice_out,
    output logic [VOICES-1:0] voice_active,
    output logic              buzz,
    output logic              drop
);
    localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;

    typedef enum logic [2:0] {IDLE, DATA1, DATA2, SKIP1, SKIP2} state_t;

    state_t     state, state_n;
    logic       rs_on, rs_on_n;
    logic       skip2, skip2_n;
    logic [6:0] note_q, note_n;
    logic       issue;
    logic       msg_on;

    logic       is_rt, is_sys, is_chan, is_data, chan_ok;
    logic [3:0] hi;

    assign hi      = rx_byte[7:4];
    assign is_rt   = (hi == 4'hF) && rx_byte[3];
    assign is_sys  = (hi == 4'hF) && !rx_byte[3];
    assign is_chan = rx_byte[7] && (hi != 4'hF);
    assign is_data = !rx_byte[7];
    assign chan_ok = (OMNI != 0) || (rx_byte[3:0] == 4'(CHANNEL));
    assign msg_on  = rs_on && (rx_byte[6:0] != 7'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rs_on  <= 1'b0;
            skip2  <= 1'b0;
            note_q <= '0;
        end else begin
            state  <= state_n;
            rs_on  <= rs_on_n;
            skip2  <= skip2_n;
            note_q <= note_n;
        end
    end

    always_comb begin
        state_n = state;
        rs_on_n = rs_on;
        skip2_n = skip2;
        note_n  = note_q;
        issue   = 1'b0;
        if (rx_valid) begin
            unique case (1'b1)
                is_rt: ;
                is_sys: state_n = IDLE;
                is_chan: begin
                    if ((hi == 4'h8 || hi == 4'h9) && chan_ok) begin
                        rs_on_n = hi[0];
                        state_n = DATA1;
                    end else begin
                        // program change / channel pressure carry one data byte
                        skip2_n = !(hi == 4'hC || hi == 4'hD);
                        state_n = skip2_n ? SKIP2 : SKIP1;
                    end
                end
                is_data: begin
                    case (state)
                        DATA1: begin
                            note_n  = rx_byte[6:0];
                            state_n = DATA2;
                        end
                        DATA2: begin
                            issue   = 1'b1;
                            state_n = DATA1;
                        end
                        SKIP2: state_n = SKIP1;
                        SKIP1: state_n = skip2 ? SKIP2 : SKIP1;
                        default: ;
                    endcase
                end
            endcase
        end
    end

    // period from note: base table for octave 4, shifted per octave
    logic [3:0]       semi, oct;
    logic [16:0]      base;
    logic [CNT_W-1:0] new_period, new_high;

    assign oct  = 4'(note_q / 7'd12);
    assign semi = 4'(note_q % 7'd12);

    always_comb begin
        case (semi)
            4'd0:    base = 17'd91736;
            4'd1:    base = 17'd86587;
            4'd2:    base = 17'd81728;
            4'd3:    base = 17'd77141;
            4'd4:    base = 17'd72811;
            4'd5:    base = 17'd68724;
            4'd6:    base = 17'd64867;
            4'd7:    base = 17'd61227;
            4'd8:    base = 17'd57790;
            4'd9:    base = 17'd54547;
            4'd10:   base = 17'd51485;
            default: base = 17'd48596;
        endcase
        if (oct < 4'd4)
            new_period = CNT_W'(base) << (4'd4 - oct);
        else
            new_period = CNT_W'(base) >> (oct - 4'd4);
    end

`ifdef M2S_VELOCITY_DUTY_EN
    logic [CNT_W+6:0] prod;
    assign prod     = (CNT_W+7)'(new_period) * (CNT_W+7)'(rx_byte[6:0]);
    assign new_high = CNT_W'(prod >> 8);
`else
    assign new_high = new_period >> 1;
`endif

    logic [VOICES-1:0] active, out;
    logic [6:0]        vnote  [VOICES];
    logic [CNT_W-1:0]  per    [VOICES];
    logic [CNT_W-1:0]  high   [VOICES];
    logic [CNT_W-1:0]  cnt    [VOICES];
    logic [CNT_W-1:0]  cnt_nx [VOICES];

    logic          hit, has_free;
    logic [IW-1:0] hit_idx, free_idx, load_idx;
    logic          do_on, do_off, load_en;

    // descending scan so the lowest index wins
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (active[i] && vnote[i] == note_q) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (!active[i]) begin
                has_free = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    assign do_on    = issue && msg_on;
    assign do_off   = issue && !msg_on && hit;
    assign load_en  = do_on && (hit || has_free);
    assign load_idx = hit ? hit_idx : free_idx;

    always_comb begin
        for (int i = 0; i < VOICES; i++)
            cnt_nx[i] = (cnt[i] == per[i] - 1'b1) ? '0 : cnt[i] + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop   <= 1'b0;
            active <= '0;
            out    <= '0;
            for (int i = 0; i < VOICES; i++) begin
                vnote[i] <= '0;
                per[i]   <= '0;
                high[i]  <= '0;
                cnt[i]   <= '0;
            end
        end else begin
            drop <= do_on && !hit && !has_free;
            for (int i = 0; i < VOICES; i++) begin
                if (load_en && load_idx == IW'(i)) begin
                    active[i] <= 1'b1;
                    vnote[i]  <= note_q;
                    per[i]    <= new_period;
                    high[i]   <= new_high;
                    cnt[i]    <= '0;
                    out[i]    <= (new_high != '0);
                end else if (do_off && hit_idx == IW'(i)) begin
                    active[i] <= 1'b0;
                    cnt[i]    <= '0;
                    out[i]    <= 1'b0;
                end else if (active[i]) begin
                    cnt[i] <= cnt_nx[i];
                    out[i] <= (cnt_nx[i] < high[i]);
                end
            end
        end
    end

    assign voice_out    = out;
    assign voice_active = active;
    assign buzz         = |out;
endmodule
